brute_force_word_generator: RTL and testbench

//  Parametrised multi-character brute-force candidate generator. Emits every word of
//  NUM_CHARS characters over [CHAR_FIRST..CHAR_LAST] as an odometer of chained lanes,
//  one word per valid/ready handshake. Lane 0 (least significant) uses a start offset
//  and stride, so N parallel instances partition the keyspace (offset=k, stride=N).

---
 rtl/brute_force_word_generator_if.sv | 35 +++
 rtl/brute_force_word_generator.sv | 135 +++++++++++++
 tb/tb_brute_force_word_generator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/brute_force_word_generator_if.sv
// Handshake/data bundle between a brute-force word generator and its driver.
// master: drives control and outReady, observes the candidate stream and status.
// slave : the generator itself.
//   start, abort          sweep control
//   startingPosition      lane-0 alphabet offset
//   increment             lane-0 stride (0 behaves as 1)
//   outReady / outValid   candidate handshake
//   word, lastWord        candidate and final-word flag
//   busy, done, error     status (done/error are single-cycle pulses)
interface brute_force_word_generator_if #(
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned STRIDE_W  = 3
);
    logic                     start;
    logic                     abort;
    logic [7:0]               startingPosition;
    logic [STRIDE_W-1:0]      increment;
    logic                     outReady;
    logic                     outValid;
    logic [8*NUM_CHARS-1:0]   word;
    logic                     lastWord;
    logic                     busy;
    logic                     done;
    logic                     error;

    modport master (
        output start, abort, startingPosition, increment, outReady,
        input  outValid, word, lastWord, busy, done, error
    );

    modport slave (
        input  start, abort, startingPosition, increment, outReady,
        output outValid, word, lastWord, busy, done, error
    );
endinterface

// File: rtl/brute_force_word_generator.sv
// Multi-character brute-force candidate generator. Lanes form an odometer over the
// alphabet [CHAR_FIRST..CHAR_LAST]; lane 0 starts at an offset and steps by a stride so
// several instances can split the keyspace. One word is emitted per valid/ready transfer.
// Ports:
//   clock   rising-edge clock
//   resetN  asynchronous active-low reset
//   bus     slave side of brute_force_word_generator_if (control, stream, status)
module brute_force_word_generator #(
    parameter int unsigned NUM_CHARS  = 4,
    parameter logic [7:0]  CHAR_FIRST = 8'h61,
    parameter logic [7:0]  CHAR_LAST  = 8'h7A,
    parameter int unsigned STRIDE_W   = 3
) (
    input logic                         clock,
    input logic                         resetN,
    brute_force_word_generator_if.slave bus
);

    // Range is 9 bits wide so a full 256-symbol alphabet still compares correctly.
    localparam logic [8:0] Range   = {1'b0, CHAR_LAST} - {1'b0, CHAR_FIRST} + 9'd1;
    localparam logic [7:0] RangeM1 = CHAR_LAST - CHAR_FIRST;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [7:0]          idx_q [NUM_CHARS];
    logic [7:0]          idx_d [NUM_CHARS];
    logic [7:0]          offset_q, offset_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic                error_q, error_d;

    logic [8:0]          lane0_sum;
    logic                lane0_wrap;
    logic                upper_all_max;
    logic                last_word;
    logic                carry;

    // Lane-0 sum is one bit wider than the index so it can never overflow.
    always_comb begin
        lane0_sum     = {1'b0, idx_q[0]} + 9'(stride_q);
        lane0_wrap    = lane0_sum > {1'b0, RangeM1};
        upper_all_max = 1'b1;
        for (int i = 1; i < int'(NUM_CHARS); i++) begin
            upper_all_max = upper_all_max & (idx_q[i] == RangeM1);
        end
        last_word = (state_q == StRun) & lane0_wrap & upper_all_max;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        offset_d = offset_q;
        stride_d = stride_q;
        error_d  = 1'b0;
        carry    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if ({1'b0, bus.startingPosition} < Range) begin
                        offset_d = bus.startingPosition;
                        stride_d = (bus.increment == '0) ? STRIDE_W'(1) : bus.increment;
                        idx_d[0] = bus.startingPosition;
                        for (int i = 1; i < int'(NUM_CHARS); i++) begin
                            idx_d[i] = '0;
                        end
                        state_d = StRun;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort takes precedence over a transfer in the same cycle.
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.outReady) begin
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        carry    = lane0_wrap;
                        idx_d[0] = lane0_wrap ? offset_q : lane0_sum[7:0];
                        for (int i = 1; i < int'(NUM_CHARS); i++) begin
                            if (carry) begin
                                if (idx_q[i] == RangeM1) begin
                                    idx_d[i] = '0;
                                end else begin
                                    idx_d[i] = idx_q[i] + 8'd1;
                                    carry    = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= StIdle;
            offset_q <= '0;
            stride_q <= STRIDE_W'(1);
            error_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_CHARS); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            stride_q <= stride_d;
            error_q  <= error_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        bus.word = '0;
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
            bus.word[8*i +: 8] = CHAR_FIRST + idx_q[i];
        end
        bus.outValid = (state_q == StRun);
        bus.busy     = (state_q == StRun);
        bus.done     = (state_q == StDone);
        bus.lastWord = last_word;
        bus.error    = error_q;
    end

endmodule

// File: tb/tb_brute_force_word_generator.sv
// Directed bench for brute_force_word_generator with two lanes over 'a'..'z'.
module tb_brute_force_word_generator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    brute_force_word_generator_if #(.NUM_CHARS(2), .STRIDE_W(3)) bus ();

    brute_force_word_generator #(
        .NUM_CHARS  (2),
        .CHAR_FIRST (8'h61),
        .CHAR_LAST  (8'h7A),
        .STRIDE_W   (3)
    ) dut (
        .clock  (clk),
        .resetN (rst_n),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] pos, input logic [2:0] inc);
        bus.start            = 1'b1;
        bus.startingPosition = pos;
        bus.increment        = inc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.startingPosition = '0;
        bus.increment = '0; bus.outReady = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.outValid); end
        checks++; if (bus.word !== 16'h6161) begin errors++; $display("FAIL reset_word got=%h exp=6161", bus.word); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", bus.error); end
        checks++; if (bus.lastWord !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", bus.lastWord); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Full sweep against a lane model; optional 5-cycle stall on the 51st word.
    task automatic test_sweep(input int offset, input int stride, input int exp_count,
                              input logic [15:0] exp_last, input int probe_idx,
                              input logic [15:0] probe_word, input bit stall);
        int m0, m1, acc, stall_left, eff;
        bit finished, saw_last;
        logic [15:0] last_w, exp_w;
        logic exp_l;
        m0 = offset; m1 = 0; acc = 0; finished = 0; saw_last = 0; last_w = '0;
        stall_left = stall ? 5 : 0;
        eff = (stride == 0) ? 1 : stride;
        bus.outReady = 1'b1;
        do_start(8'(offset), 3'(stride));
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (bus.outValid) begin
                exp_w = {8'h61 + 8'(m1), 8'h61 + 8'(m0)};
                exp_l = (m0 + eff > 25) && (m1 == 25);
                checks++;
                if (bus.word !== exp_w) begin
                    errors++; $display("FAIL sweep_word n=%0d got=%h exp=%h", acc, bus.word, exp_w);
                end
                checks++;
                if (bus.lastWord !== exp_l) begin
                    errors++; $display("FAIL sweep_last n=%0d got=%b exp=%b", acc, bus.lastWord, exp_l);
                end
                if (acc == probe_idx) begin
                    checks++;
                    if (bus.word !== probe_word) begin
                        errors++; $display("FAIL sweep_probe got=%h exp=%h", bus.word, probe_word);
                    end
                end
                if (stall && acc == 50 && stall_left > 0) begin
                    bus.outReady = 1'b0;
                    stall_left--;
                end else begin
                    bus.outReady = 1'b1;
                    acc++;
                    if (bus.lastWord) begin saw_last = 1; last_w = bus.word; end
                    if (m0 + eff <= 25) m0 += eff;
                    else begin m0 = offset; m1 = (m1 == 25) ? 0 : m1 + 1; end
                end
            end else begin
                checks++;
                if (!saw_last || bus.done !== 1'b1) begin
                    errors++; $display("FAIL sweep_done saw_last=%0d got=%b exp=1", saw_last, bus.done);
                end
                finished = 1;
            end
            step();
        end
        checks++; if (!finished) begin errors++; $display("FAIL sweep_timeout got=running exp=finished"); end
        checks++; if (acc != exp_count) begin errors++; $display("FAIL sweep_count got=%0d exp=%0d", acc, exp_count); end
        checks++; if (last_w !== exp_last) begin errors++; $display("FAIL sweep_lastword got=%h exp=%h", last_w, exp_last); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL sweep_done_width got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sweep_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_error();
        bus.outReady = 1'b1;
        do_start(8'd26, 3'd1);
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", bus.error); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL err_valid got=%b exp=0", bus.outValid); end
        step();
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL err_width got=%b exp=0", bus.error); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL err_valid2 got=%b exp=0", bus.outValid); end
        do_start(8'hFF, 3'd0);
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL err_ff got=%b exp=1", bus.error); end
        step();
    endtask

    task automatic test_abort();
        bus.outReady = 1'b1;
        do_start(8'd0, 3'd1);
        for (int i = 0; i < 100; i++) step();
        // 100 transfers: lane1 = 3 ('d'), lane0 = 22 ('w').
        checks++; if (bus.word !== 16'h6477) begin errors++; $display("FAIL abort_pre got=%h exp=6477", bus.word); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", bus.outValid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done2 got=%b exp=0", bus.done); end
        // start and abort together in IDLE: start wins.
        bus.abort = 1'b1;
        do_start(8'd0, 3'd1);
        bus.abort = 1'b0;
        checks++; if (bus.outValid !== 1'b1) begin errors++; $display("FAIL restart_valid got=%b exp=1", bus.outValid); end
        checks++; if (bus.word !== 16'h6161) begin errors++; $display("FAIL restart_word got=%h exp=6161", bus.word); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL abort2_valid got=%b exp=0", bus.outValid); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.outReady = 1'b1;
        do_start(8'd0, 3'd1);
        for (int i = 0; i < 10; i++) step();
        checks++; if (bus.word !== 16'h616B) begin errors++; $display("FAIL rmid_pre got=%h exp=616b", bus.word); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.outValid); end
        checks++; if (bus.word !== 16'h6161) begin errors++; $display("FAIL rmid_word got=%h exp=6161", bus.word); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
        do_start(8'd0, 3'd0);
        checks++; if (bus.word !== 16'h6161) begin errors++; $display("FAIL stride0_w0 got=%h exp=6161", bus.word); end
        step();
        checks++; if (bus.word !== 16'h6162) begin errors++; $display("FAIL stride0_w1 got=%h exp=6162", bus.word); end
        step();
        checks++; if (bus.word !== 16'h6163) begin errors++; $display("FAIL stride0_w2 got=%h exp=6163", bus.word); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep(0, 1, 676, 16'h7A7A, 26, 16'h6261, 1'b0);
        // Offset 1 stride 3 visits b,e,...,w,z on lane 0, so the sweep ends on "zz".
        test_sweep(1, 3, 234, 16'h7A7A, 9, 16'h6262, 1'b0);
        test_sweep(2, 5, 130, 16'h7A77, 5, 16'h6263, 1'b1);
        test_error();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
